// File: rtl/s2p_collector.sv
// Serial-to-parallel collector: assembles WIDTH shifted bits into a word and queues it in a 2-entry FIFO.
// Word visible 1 clk after last bit; holds under d_ready=0, drops new words with sticky overrun when full.
module s2p_collector #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     d_in,
  input  logic                     shift,
  input  logic                     clear,
  output logic [WIDTH-1:0]         d_out,
  output logic                     d_valid,
  input  logic                     d_ready,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overrun
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] mem [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             capture;
  logic             last_bit;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr_ok;
  logic [CW-1:0]    pos;

  assign capture  = shift & ~clear;
  assign last_bit = (bit_cnt == CW'(WIDTH-1));
  assign push     = capture & last_bit;
  assign d_valid  = (count != 2'd0);
  assign full     = (count == 2'd2);
  assign pop      = d_valid & d_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign wr_ok    = push & (~full | pop);
  assign wr_ptr   = rd_ptr ^ count[0];
  assign pos      = LSB_FIRST ? bit_cnt : (CW'(WIDTH-1) - bit_cnt);
  assign busy     = (state == RECV);
  assign d_out    = d_valid ? mem[rd_ptr] : '0;

  always_comb begin
    next_word      = shreg;
    next_word[pos] = d_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      overrun <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      if (clear) begin
        state   <= IDLE;
        bit_cnt <= '0;
        shreg   <= '0;
      end else if (shift) begin
        if (last_bit) begin
          state   <= IDLE;
          bit_cnt <= '0;
          shreg   <= '0;
        end else begin
          state   <= RECV;
          bit_cnt <= bit_cnt + CW'(1);
          shreg   <= next_word;
        end
      end
      if (wr_ok) mem[wr_ptr] <= next_word;
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, wr_ok} - {1'b0, pop};
      if (push && full && !pop) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_s2p_collector.sv
// Bench for s2p_collector: LSB-first and MSB-first instances share stimulus, each checked by its own scoreboard.
module tb_s2p_collector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       d_in;
  logic       shift;
  logic       clear;
  logic       d_ready;
  logic [7:0] d_out0, d_out1;
  logic       d_valid0, d_valid1;
  logic       busy0, busy1;
  logic [2:0] bit_cnt0, bit_cnt1;
  logic       overrun0, overrun1;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];

  always #5 clk = ~clk;

  s2p_collector #(.WIDTH(8), .LSB_FIRST(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .shift(shift), .clear(clear),
    .d_out(d_out0), .d_valid(d_valid0), .d_ready(d_ready),
    .busy(busy0), .bit_cnt(bit_cnt0), .overrun(overrun0));

  s2p_collector #(.WIDTH(8), .LSB_FIRST(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .shift(shift), .clear(clear),
    .d_out(d_out1), .d_valid(d_valid1), .d_ready(d_ready),
    .busy(busy1), .bit_cnt(bit_cnt1), .overrun(overrun1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction

  // Transfers complete at the next posedge; inputs are stable at negedge.
  always @(negedge clk) begin
    if (rst_n && d_ready && d_valid0) begin
      if (exp_q0.size() == 0) check("sb0_unexpected", 32'(exp_q0.size()), 32'd1);
      else check("sb0_word", d_out0, exp_q0.pop_front());
    end
    if (rst_n && d_ready && d_valid1) begin
      if (exp_q1.size() == 0) check("sb1_unexpected", 32'(exp_q1.size()), 32'd1);
      else check("sb1_word", d_out1, exp_q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bits go out w[0] first; the MSB-first instance therefore sees rev8(w).
  task automatic send_word(input logic [7:0] w, input bit expect_it, input int gap, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      tick();
      shift = 1'b1;
      d_in  = w[i];
      if (i == 7) begin
        if (rdy_last) d_ready = 1'b1;
        if (expect_it) begin
          exp_q0.push_back(w);
          exp_q1.push_back(rev8(w));
        end
      end
      if (i != 7) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          shift = 1'b0;
          d_in  = 1'($urandom_range(0, 1));
        end
      end
    end
    tick();
    shift = 1'b0;
    d_in  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; d_in = 1'b0; shift = 1'b0; clear = 1'b0; d_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_valid", d_valid0, 1'b0);
    check("rst_dout", d_out0, 8'h00);
    check("rst_busy", busy0, 1'b0);
    check("rst_cnt", bit_cnt0, 3'd0);
    check("rst_ovr", overrun0, 1'b0);
    tick();
    rst_n = 1'b1;

    // A5 with d_ready=1: valid for exactly one cycle, one clock after the 8th bit
    send_word(8'hA5, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("a5_valid", d_valid0, 1'b1);
    check("a5_dout", d_out0, 8'hA5);
    @(negedge clk);
    check("a5_valid_gone", d_valid0, 1'b0);
    check("a5_dout_zero", d_out0, 8'h00);

    // bit order: 1,1,0.. gives 03 LSB-first and C0 MSB-first; gaps exercise shift=0 hold
    send_word(8'h03, 1'b1, 0, 1'b0);
    send_word(8'h6E, 1'b1, 2, 1'b0);
    tick();
    shift = 1'b1; d_in = 1'b1;
    tick();
    shift = 1'b0; d_in = 1'b0;
    @(negedge clk);
    check("mid_cnt", bit_cnt0, 3'd1);
    check("mid_busy", busy0, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    check("hold_cnt", bit_cnt0, 3'd1);
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // overrun: 11,22 buffered, 33 dropped
    d_ready = 1'b0;
    send_word(8'h11, 1'b1, 0, 1'b0);
    send_word(8'h22, 1'b1, 0, 1'b0);
    @(negedge clk);
    check("full_ovr_clear", overrun0, 1'b0);
    send_word(8'h33, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("ovr_set", overrun0, 1'b1);
    check("ovr_head", d_out0, 8'h11);
    repeat (3) tick();
    @(negedge clk);
    check("stall_head", d_out0, 8'h11);
    check("stall_valid", d_valid0, 1'b1);
    d_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    check("drained_valid", d_valid0, 1'b0);
    check("ovr_sticky", overrun0, 1'b1);

    // clear with shift mid-word: the partial and the clearing bit are discarded
    tick(); shift = 1'b1; d_in = 1'b1;
    tick(); d_in = 1'b0;
    tick(); d_in = 1'b1;
    tick(); clear = 1'b1; d_in = 1'b1;
    tick(); clear = 1'b0; shift = 1'b0;
    @(negedge clk);
    check("clr_cnt", bit_cnt0, 3'd0);
    check("clr_busy", busy0, 1'b0);
    check("clr_ovr_kept", overrun0, 1'b1);
    send_word(8'h5A, 1'b1, 0, 1'b0);
    repeat (3) tick();

    // reset with bit_cnt=5 and one word buffered
    d_ready = 1'b0;
    send_word(8'h77, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); shift = 1'b1; d_in = 1'(i & 1);
    end
    tick(); shift = 1'b0;
    @(negedge clk);
    check("pre_rst_cnt", bit_cnt0, 3'd5);
    check("pre_rst_valid", d_valid0, 1'b1);
    tick();
    rst_n = 1'b0; d_ready = 1'b1; shift = 1'b1; clear = 1'b1;
    tick();
    rst_n = 1'b1; shift = 1'b0; clear = 1'b0;
    @(negedge clk);
    check("rst2_valid", d_valid0, 1'b0);
    check("rst2_dout", d_out0, 8'h00);
    check("rst2_cnt", bit_cnt0, 3'd0);
    check("rst2_busy", busy0, 1'b0);
    check("rst2_ovr", overrun0, 1'b0);

    // full FIFO with pop on the completing edge: no overrun, order kept
    d_ready = 1'b0;
    send_word(8'h81, 1'b1, 0, 1'b0);
    send_word(8'h82, 1'b1, 0, 1'b0);
    send_word(8'h83, 1'b1, 0, 1'b1);
    @(negedge clk);
    check("fullpop_ovr", overrun0, 1'b0);
    check("fullpop_head", d_out0, 8'h82);
    repeat (3) tick();

    // single entry with push and pop on the same edge: new word becomes head
    d_ready = 1'b0;
    send_word(8'h91, 1'b1, 0, 1'b0);
    send_word(8'h92, 1'b1, 1, 1'b1);
    @(negedge clk);
    check("onepop_head", d_out0, 8'h92);
    check("onepop_ovr", overrun0, 1'b0);

    for (int i = 0; i < 50 && (exp_q0.size() != 0 || exp_q1.size() != 0); i++) tick();
    check("drain_q0", 32'(exp_q0.size()), 32'd0);
    check("drain_q1", 32'(exp_q1.size()), 32'd0);
    @(negedge clk);
    check("end_valid", d_valid0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/s2p_collector.md
S2P_COLLECTOR -- requirements
Module: s2p_collector

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of serial bits per assembled word.
REQ-002 The block SHALL have parameter LSB_FIRST, default 1: 1 = first received bit lands in d_out[0]; 0 = first received bit lands in d_out[WIDTH-1].
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port d_in, input, 1 bit: serial data bit from the upstream serializer.
REQ-006 Port shift, input, 1 bit: d_in is valid this cycle and SHALL be captured.
REQ-007 Port clear, input, 1 bit: abort the partially assembled word.
REQ-008 Port d_out, output, WIDTH bits: head word of the output buffer.
REQ-009 Port d_valid, output, 1 bit: d_out holds a valid word.
REQ-010 Port d_ready, input, 1 bit: downstream accepts d_out this cycle.
REQ-011 Port busy, output, 1 bit: a partial word is in progress.
REQ-012 Port bit_cnt, output, clog2(WIDTH) bits: number of bits captured into the current partial word.
REQ-013 Port overrun, output, 1 bit: sticky flag, a completed word was lost.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (bit_cnt=0, busy=0) and RECV (bit_cnt 1..WIDTH-1, busy=1).
REQ-015 IDLE->RECV SHALL occur on shift=1 with clear=0; RECV->IDLE SHALL occur on the WIDTH-th captured bit or on clear=1.
REQ-016 Each captured bit SHALL be written to position bit_cnt (LSB_FIRST=1) or WIDTH-1-bit_cnt (LSB_FIRST=0); bit_cnt then SHALL increment, wrapping WIDTH-1 -> 0.
REQ-017 On the edge capturing the WIDTH-th bit, the completed word (including that bit) SHALL be pushed into a 2-entry output FIFO.
REQ-018 d_valid SHALL be 1 from the cycle after that push edge; latency from last bit's shift cycle to d_valid = 1 clock.
REQ-019 A word SHALL transfer on any rising edge where d_valid=1 and d_ready=1; the FIFO then pops.
REQ-020 While d_valid=1 and d_ready=0, d_out and d_valid SHALL hold stable.
REQ-021 d_valid=0 SHALL drive d_out to all zeros.
REQ-022 FIFO ordering SHALL be first-in first-out; d_out SHALL always show the oldest unpopped word.
REQ-023 Push into a full FIFO with no simultaneous pop: the new word SHALL be discarded, FIFO contents unchanged, overrun set to 1.
REQ-024 Push and pop on the same edge with the FIFO full: both SHALL succeed, no overrun.
REQ-025 Push and pop on the same edge with one entry: the new word SHALL become the head, occupancy stays 1.
REQ-026 overrun SHALL stay 1 until rst_n=0; clear SHALL not affect it.
REQ-027 clear=1 SHALL zero bit_cnt and the partial word and force IDLE; it SHALL not affect FIFO contents, d_valid, or d_out.
REQ-028 clear=1 and shift=1 in the same cycle: clear SHALL win; that bit SHALL be discarded.
REQ-029 shift=0 SHALL leave the partial word and bit_cnt unchanged, with no timeout.
REQ-030 d_in SHALL be ignored when shift=0.

Reset
REQ-031 On a rising edge with rst_n=0, the block SHALL set state=IDLE, bit_cnt=0, partial word=0, FIFO empty, d_valid=0, d_out=0, busy=0, overrun=0.
REQ-032 rst_n=0 SHALL override shift, clear, and d_ready in the same cycle.
REQ-033 Reset asserted mid-word or with the FIFO non-empty SHALL discard all partial and buffered data.

Verification
REQ-034 Default params, d_ready=1, shift for 8 cycles with d_in=1,0,1,0,0,1,0,1 -> d_valid=1 for one cycle, 1 clk after 8th bit, d_out=8'hA5.
REQ-035 LSB_FIRST=0, same bit sequence -> d_out=8'hA5 bit-reversed=8'hA5 is palindromic, so use 1,1,0,0,0,0,0,0 -> d_out=8'hC0 (LSB_FIRST=1 gives 8'h03).
REQ-036 d_ready=0, send words 8'h11, 8'h22, 8'h33 -> overrun=1 after third word; d_out=8'h11 stable; then d_ready=1 -> 8'h11, 8'h22 delivered, d_valid=0; overrun stays 1.
REQ-037 Send 3 bits, then clear=1 with shift=1, then a full word 8'h5A -> bit_cnt=0 after clear; only 8'h5A emitted.
REQ-038 Assert rst_n=0 with bit_cnt=5 and one word buffered -> next cycle d_valid=0, d_out=0, bit_cnt=0, busy=0, overrun=0.
REQ-039 FIFO full, d_ready=1 on the edge the next word completes -> no overrun; words emitted in order.
